// File: rtl/fifo_pkg.sv
// +----------------------------------------------------------------------------
// | fifo_pkg : shared types and defaults for the FIFO read-side packer
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

  localparam int DEF_IN_WIDTH = 8;
  localparam int DEF_RATIO    = 4;

  // Lane counter must represent 0..ratio inclusive.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_RATIO);

endpackage

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// +----------------------------------------------------------------------------
// | fifo_rd_packer : drains a registered-read FIFO and packs RATIO words into
// | one wide valid/ready beat. Partial-word flush: FIFO_RD_PACKER_FLUSH_EN.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int RATIO    = DEF_RATIO
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      fifo_rd_en_o,
  input  logic [IN_WIDTH-1:0]       fifo_dout_i,
  input  logic                      fifo_empty_i,
  input  logic                      flush_i,
  output logic [IN_WIDTH*RATIO-1:0] m_data_o,
  output logic [RATIO-1:0]          m_keep_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 pend_q;
  logic                 pend_d;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 valid_q;
  logic [CNT_W:0]       inflight;
  logic                 block_rd;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic                 flush_req_q;
  logic [RATIO-1:0]     keep_q;
  assign block_rd = flush_req_q;
  assign m_keep_o = keep_q;
`else
  logic                 unused_flush;
  assign unused_flush = flush_i;
  assign block_rd     = 1'b0;
  assign m_keep_o     = '1;
`endif

  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;

  // Strobe is gated by empty in the same cycle and counts the in-flight read.
  always_comb begin
    inflight     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
    fifo_rd_en_o = !rst_i && (state_q == FILL) && !fifo_empty_i && !block_rd &&
                   (inflight < {1'b0, RATIO_C});
    cnt_d        = pend_q ? cnt_q + CNT_W'(1) : cnt_q;
    pend_d       = fifo_rd_en_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      flush_req_q <= 1'b0;
      keep_q      <= '0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          pend_q <= pend_d;
          cnt_q  <= cnt_d;
          if (pend_q) begin
            data_q[cnt_q*IN_WIDTH +: IN_WIDTH] <= fifo_dout_i;
          end
          if (cnt_d == RATIO_C) begin
            state_q     <= OUT;
            valid_q     <= 1'b1;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            keep_q      <= '1;
            flush_req_q <= flush_i;
`endif
          end
`ifdef FIFO_RD_PACKER_FLUSH_EN
          // Flush completes once the last in-flight word has landed.
          else if (flush_req_q && !pend_d) begin
            flush_req_q <= flush_i;
            if (cnt_d != '0) begin
              state_q <= OUT;
              valid_q <= 1'b1;
              for (int i = 0; i < RATIO; i++) begin
                keep_q[i] <= (i < int'(cnt_d));
              end
            end
          end else begin
            flush_req_q <= flush_req_q | flush_i;
          end
`endif
        end
        OUT: begin
`ifdef FIFO_RD_PACKER_FLUSH_EN
          flush_req_q <= flush_req_q | flush_i;
`endif
          if (m_ready_i) begin
            state_q <= FILL;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            keep_q  <= '0;
`endif
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Downstream consumer of `sync_fifo`. It drains narrow words through the FIFO read port and packs RATIO consecutive words into one wide word. The wide word is presented on a valid/ready output stream. The block sits between the byte FIFO and any wide-datapath sink such as a bus master or a wide register bank, and it owns all FIFO read timing.

## Interface
Parameters:
- `IN_WIDTH`, default 8: FIFO word width; must match the `sync_fifo` `FIFO_WIDTH`.
- `RATIO`, default 4: input words per output word; legal range ≥ 2.
- Derived localparam `OUT_WIDTH` = `IN_WIDTH*RATIO`.

Ports:
- `clk_i` input 1: single clock, shared with `sync_fifo`.
- `rst_i` input 1: reset, synchronous, active-high.
- `fifo_rd_en_o` output 1: read strobe to the FIFO `rd_en_i`.
- `fifo_dout_i` input `IN_WIDTH`: FIFO `dout_o`.
- `fifo_empty_i` input 1: FIFO `empty_o`.
- `flush_i` input 1: single-cycle request to emit a partial word.
- `m_data_o` output `OUT_WIDTH`: packed word.
- `m_keep_o` output `RATIO`: per-lane valid mask.
- `m_valid_o` output 1: packed word available.
- `m_ready_i` input 1: sink accepts the word.

## Operation
- The FIFO read port is registered. Data requested with `fifo_rd_en_o=1` in cycle N appears on `fifo_dout_i` in cycle N+1 and is captured on that cycle's edge.
- State:
  - `cnt`, range 0..RATIO: lanes filled.
  - `pend`, 1 bit: a read is in flight.
  - FSM with states FILL and OUT.
- FILL:
  - `fifo_rd_en_o` = `!fifo_empty_i && !flush_req && (cnt + pend < RATIO)`. The strobe is never asserted while empty.
  - Captured data goes into lane `cnt`, bits `[cnt*IN_WIDTH +: IN_WIDTH]`. The first word lands in the LSBs.
  - `cnt` increments on each capture.
  - When `cnt` reaches RATIO with `pend=0`: go to OUT, assert `m_valid_o`, set `m_keep_o` to all-ones.
- OUT:
  - No FIFO reads are issued.
  - `m_data_o`, `m_keep_o`, and `m_valid_o` hold stable until `m_valid_o && m_ready_i`.
  - On that handshake: go to FILL, set `cnt=0`, clear the data register to 0.
- Throughput: at most one output word per RATIO+1 cycles. There is no prefetch during OUT.
- Reset: `fifo_rd_en_o=0`, `m_valid_o=0`, `m_data_o=0`, `m_keep_o=0`, `cnt=0`, `pend=0`, `flush_req=0`, state FILL.
- `m_keep_o` is all-ones whenever `m_valid_o=1` and the flush feature is compiled out.
- Reset mid-operation:
  - A partially filled word is discarded.
  - Any data returning in the cycle after `rst_i` deasserts is ignored, because `pend` was cleared.
  - `rst_i` and the FIFO reset are driven from the same source.

## Timing
- Capture: cycle N with `fifo_rd_en_o=1` → lane written at the N+1 edge. The next strobe may be issued in cycle N+1, giving back-to-back reads.
- Fill latency, RATIO=4, FIFO non-empty throughout: first strobe at cycle 0, `m_valid_o` rises at cycle 5.
- Sink side: `m_ready_i` may be high before `m_valid_o`; the transfer occurs on the first cycle both are high.
- `fifo_empty_i` rising mid-word: reads pause and `cnt` holds. There is no timeout.

## Configuration
- Macro: `FIFO_RD_PACKER_FLUSH_EN`.
- Defined:
  - A `flush_i` pulse sets sticky `flush_req`. While `flush_req` is set, new reads are blocked.
  - Once `pend=0` in FILL:
    - If `cnt>0`: go to OUT with `m_keep_o[i]=1` for `i<cnt`. Unused lanes read as 0 and `flush_req` clears.
    - If `cnt==0`: `flush_req` clears with no output.
  - A flush arriving in OUT is serviced after the current handshake.
- Undefined: `flush_i` is ignored and `m_keep_o` is constant all-ones. Reset and idle values are all-ones as well.

## Structure
- Package `fifo_pkg`:
  - FSM state enum {FILL, OUT}.
  - Lane-index width constant `$clog2(RATIO+1)`, and the default `IN_WIDTH` and `RATIO`.
- No sub-module. The lane write is a single indexed part-select into the output register.

## Test plan
- RATIO=4, FIFO preloaded with 0x11,0x22,0x33,0x44, `m_ready_i=1` → one beat with `m_data_o=0x44332211` and `m_keep_o=4'b1111`, first strobe-to-valid 5 cycles.
- Eight words 0x01..0x08, `m_ready_i` low for 10 cycles then high:
  - `m_data_o=0x04030201` holds stable and no `fifo_rd_en_o` is issued while stalled.
  - The second beat is `0x08070605`.
- FIFO empties after 2 words, third word written 20 cycles later → `cnt` holds at 2 and `fifo_rd_en_o` stays 0 while empty; correct packing resumes.
- Flush enabled: words 0xAA,0xBB then a `flush_i` pulse → `m_data_o=0x0000BBAA`, `m_keep_o=4'b0011`. A flush with `cnt=0` produces no beat.
- `rst_i` asserted with `cnt=3` and a read in flight → all outputs are 0 next cycle. The next full beat after reset contains only post-reset words.
- Random FIFO writes, `rd_en` and `m_ready_i` over 1000 cycles, scoreboarded against a queue model → no loss, no duplication, and never a read while empty.
